// File: rtl/mips_register_file.sv
// Two-read, one-write MIPS general-purpose register file with $0 hardwired to zero,
// same-cycle write-to-read bypass, and a wrapping count of committed writes.
module mips_register_file #(
  parameter int                 DATA_W  = 32,
  parameter int                 ADDR_W  = 5,
  parameter logic [DATA_W-1:0]  SP_INIT = 32'h0000_03FC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic              reg_write,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  output logic [7:0]        wr_count
);

  localparam int NREG   = 1 << ADDR_W;
  localparam int SP_IDX = 29;

  // Entry 0 has no storage; it is decoded to zero on the read side.
  logic [DATA_W-1:0] regs [1:NREG-1];

  logic commit;
  assign commit = reg_write && (write_reg != '0);

  // NOTE: the array is flop-based and every entry is reset, because software
  // relies on known contents ($sp in particular) straight out of reset.
  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < NREG; i++) begin
        regs[i] <= (i == SP_IDX) ? SP_INIT : '0;
      end
      wr_count <= '0;
    end else if (commit) begin
      regs[write_reg] <= write_data;
      wr_count        <= wr_count + 8'd1;
    end
  end

  // Bypass lets the ALU consume the write-back value in the cycle it is produced.
  // It is independent of rst_n, so it stays live while reset is held.
  // NOTE: every output gets a default first so no latch is inferred.
  always_comb begin
    read_data1 = '0;
    read_data2 = '0;
    if (read_reg1 != '0) begin
      if (reg_write && (write_reg == read_reg1)) read_data1 = write_data;
      else                                       read_data1 = regs[read_reg1];
    end
    if (read_reg2 != '0) begin
      if (reg_write && (write_reg == read_reg2)) read_data2 = write_data;
      else                                       read_data2 = regs[read_reg2];
    end
  end

endmodule
